// File: rtl/constants_pkg.sv
// Shared constants and types for the L1-to-memory path.
package constants_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ICLLEN = 128;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mem_arb_state_t;
  typedef enum logic {REQ_IC = 1'b0, REQ_DC = 1'b1} mem_req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; bit 0 = icache, bit 1 = dcache.
module rr_arb2
  import constants_pkg::*;
(
  input  logic [1:0]  i_req,
  input  mem_req_id_t i_last,
  output logic [1:0]  o_gnt
);
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last == REQ_DC) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory port arbiter between icache refill and dcache refill/write-back.
// Optional MEM_ARB_PERF_EN adds grant/conflict performance counters.
module mem_arbiter #(
  parameter int unsigned XLEN   = constants_pkg::XLEN,
  parameter int unsigned LINE_W = constants_pkg::ICLLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [XLEN-1:0]   ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [XLEN-1:0]   dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ic_grants,
  output logic [31:0]       perf_dc_grants,
  output logic [31:0]       perf_conflicts
`endif
);
  import constants_pkg::*;

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);

  mem_arb_state_t    r_state, w_state_nx;
  mem_req_id_t       r_owner, r_last;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [LINE_W-1:0] r_wdata, r_rdata;

  logic [1:0]        w_gnt;
  logic              w_take;
  mem_req_id_t       w_gnt_id;
  logic              w_gnt_we;
  logic [XLEN-1:0]   w_gnt_addr;
  logic [LINE_W-1:0] w_gnt_wdata;

  rr_arb2 u_rr (
    .i_req  ({dc_req_valid, ic_req_valid}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_gnt_id    = w_gnt[1] ? REQ_DC : REQ_IC;
    w_gnt_we    = w_gnt[1] & dc_req_we;
    w_gnt_addr  = w_gnt[1] ? dc_req_addr : ic_req_addr;
    w_gnt_addr[OFF_W-1:0] = '0;
    w_gnt_wdata = w_gnt[1] ? dc_req_wdata : '0;
  end

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    w_state_nx    = r_state;
    w_take        = 1'b0;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    ic_resp_valid = 1'b0;
    dc_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && (w_gnt != 2'b00)) begin
          w_take       = 1'b1;
          ic_req_ready = w_gnt[0];
          dc_req_ready = w_gnt[1];
          w_state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nx = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) w_state_nx = RESP;
      end
      RESP: begin
        ic_resp_valid = (r_owner == REQ_IC);
        dc_resp_valid = (r_owner == REQ_DC);
        w_state_nx    = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
    ic_resp_data = ic_resp_valid ? r_rdata : '0;
    dc_resp_data = dc_resp_valid ? r_rdata : '0;
  end

  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= REQ_IC;
      r_last  <= REQ_DC;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_gnt_id;
        r_last  <= w_gnt_id;
        r_we    <= w_gnt_we;
        r_addr  <= w_gnt_addr;
        r_wdata <= w_gnt_wdata;
      end
      if (r_state == WAIT && mem_resp_valid) r_rdata <= r_we ? '0 : mem_resp_data;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ic_grants <= '0;
      perf_dc_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (w_take && w_gnt[0]) perf_ic_grants <= perf_ic_grants + 32'd1;
      if (w_take && w_gnt[1]) perf_dc_grants <= perf_dc_grants + 32'd1;
      if (r_state == IDLE && ic_req_valid && dc_req_valid)
        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed requests, memory responder, monitors.
module tb_mem_arbiter;
  import constants_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [31:0]  ic_req_addr;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid, dc_req_we, dc_req_ready, dc_resp_valid;
  logic [31:0]  dc_req_addr;
  logic [127:0] dc_req_wdata, dc_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_data;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]  perf_ic_grants, perf_dc_grants, perf_conflicts;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef MEM_ARB_PERF_EN
    , .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  typedef struct { logic we; logic [31:0] addr; logic [127:0] wdata; } mreq_t;
  typedef struct { logic is_dc; logic [127:0] data; } rsp_t;
  mreq_t memq[$];
  rsp_t  respq[$];

  int checks = 0, errors = 0;
  int n_resp = 0, hs_cnt = 0;
  bit busy = 0;

  // environment knobs
  bit           rd_ovr_en = 0, spur_en = 0, rand_rdy = 0;
  logic [127:0] rd_ovr = '0;
  int           resp_delay = 1, stall_left = 0, rsp_wait = -1;
  logic [31:0]  rsp_addr;
  logic         rsp_we;

  // reference model state
  mem_req_id_t m_last = REQ_DC;
  int m_nic = 0, m_ndc = 0, m_ntie = 0;

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (rd_ovr_en) return rd_ovr;
    return {a ^ 32'h0F0F_1234, a * 32'h9E37_79B1, ~a, a + 32'h1357_9BDF};
  endfunction

  // memory responder
  initial begin
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      if (rsp_wait == 0) begin
        mem_resp_valid = 1;
        if (!rsp_we) mem_resp_data = mem_line(rsp_addr);
        rsp_wait = -1;
      end else if (rsp_wait > 0) begin
        rsp_wait--;
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        mem_resp_valid = 1;
      end
      if (stall_left > 0 && mem_req_valid) begin
        mem_req_ready = 0;
        stall_left--;
      end else begin
        mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (mem_req_valid && mem_req_ready && rsp_wait < 0) begin
        rsp_addr = mem_req_addr;
        rsp_we   = mem_req_we;
        rsp_wait = resp_delay;
        hs_cnt++;
      end
    end
  end

  // memory-side monitor
  initial begin
    bit pv = 0, phs = 0;
    mreq_t p, e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin pv = 0; continue; end
      if (mem_req_valid) begin
        if (pv && !phs) begin
          checks++;
          if (mem_req_we !== p.we || mem_req_addr !== p.addr || mem_req_wdata !== p.wdata) begin
            errors++;
            $display("FAIL mem_stable: addr=%h we=%b, held addr=%h we=%b", mem_req_addr, mem_req_we, p.addr, p.we);
          end
        end
        if (mem_req_ready) begin
          checks++;
          if (memq.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: addr=%h we=%b, no request expected", mem_req_addr, mem_req_we);
          end else begin
            e = memq.pop_front();
            if (mem_req_we !== e.we || mem_req_addr !== e.addr || (e.we && mem_req_wdata !== e.wdata)) begin
              errors++;
              $display("FAIL mem_req: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                       mem_req_addr, mem_req_we, mem_req_wdata, e.addr, e.we, e.wdata);
            end
          end
        end
      end else if (pv && !phs) begin
        checks++; errors++;
        $display("FAIL mem_valid_drop: valid=0, expected 1 until ready");
      end
      pv = mem_req_valid; phs = mem_req_ready;
      p.we = mem_req_we; p.addr = mem_req_addr; p.wdata = mem_req_wdata;
    end
  end

  // requester-side monitor
  initial begin
    rsp_t e;
    logic [127:0] act;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) continue;
      if (ic_req_ready || dc_req_ready) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL ready_while_busy: ic_ready=%b dc_ready=%b, expected 0", ic_req_ready, dc_req_ready);
        end
        busy = 1;
      end
      if (ic_resp_valid || dc_resp_valid) begin
        n_resp++; busy = 0; checks++;
        act = dc_resp_valid ? dc_resp_data : ic_resp_data;
        if (respq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: ic=%b dc=%b data=%h", ic_resp_valid, dc_resp_valid, act);
        end else begin
          e = respq.pop_front();
          if ({dc_resp_valid, ic_resp_valid} !== (e.is_dc ? 2'b10 : 2'b01) || act !== e.data) begin
            errors++;
            $display("FAIL resp: dc=%b ic=%b data=%h, expected dc=%b data=%h",
                     dc_resp_valid, ic_resp_valid, act, e.is_dc, e.data);
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string nm);
    logic [127:0] agg;
    agg = {ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, mem_req_valid, mem_req_we} |
          128'(mem_req_addr) | mem_req_wdata | ic_resp_data | dc_resp_data;
`ifdef MEM_ARB_PERF_EN
    agg = agg | 128'(perf_ic_grants) | 128'(perf_dc_grants) | 128'(perf_conflicts);
`endif
    checks++;
    if (agg !== '0) begin
      errors++;
      $display("FAIL %s: outputs OR = %h, expected 0", nm, agg);
    end
  endtask

  task automatic model_clear();
    memq.delete(); respq.delete();
    busy = 0; m_last = REQ_DC; m_nic = 0; m_ndc = 0; m_ntie = 0;
    ic_req_valid = 0; dc_req_valid = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    model_clear();
    #1 check_outputs_zero("reset_state");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic add_ic(input logic [31:0] a);
    ic_req_valid = 1; ic_req_addr = a;
  endtask

  task automatic add_dc(input logic we, input logic [31:0] a, input logic [127:0] wd);
    dc_req_valid = 1; dc_req_we = we; dc_req_addr = a; dc_req_wdata = wd;
  endtask

  // Called at a falling edge with requests driven; returns one edge after the accept.
  task automatic serve_one(output bit won_dc);
    int n = 0;
    bit both, exp_dc;
    mreq_t mr;
    rsp_t rr;
    won_dc = 0;
    #1;
    while (!(ic_req_ready || dc_req_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL grant_timeout: no ready in 200 cycles, expected a grant");
      return;
    end
    both   = ic_req_valid && dc_req_valid;
    exp_dc = both ? (m_last == REQ_IC) : dc_req_valid;
    if ({dc_req_ready, ic_req_ready} !== (exp_dc ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: dc_ready=%b ic_ready=%b, expected dc=%b", dc_req_ready, ic_req_ready, exp_dc);
    end
    m_last = exp_dc ? REQ_DC : REQ_IC;
    if (both) m_ntie++;
    if (exp_dc) begin
      m_ndc++;
      mr.we = dc_req_we; mr.addr = dc_req_addr & 32'hFFFF_FFF0; mr.wdata = dc_req_wdata;
    end else begin
      m_nic++;
      mr.we = 0; mr.addr = ic_req_addr & 32'hFFFF_FFF0; mr.wdata = '0;
    end
    rr.is_dc = exp_dc;
    rr.data  = mr.we ? '0 : mem_line(mr.addr);
    memq.push_back(mr); respq.push_back(rr);
    @(negedge clk);
    if (exp_dc) dc_req_valid = 0; else ic_req_valid = 0;
    won_dc = exp_dc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (respq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", respq.size());
    end
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    bit w;
    int h0, nr, n;
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_we = 0; dc_req_addr = '0; dc_req_wdata = '0;
    reset_dut();

    // single icache refill
    rd_ovr_en = 1; rd_ovr = {16{8'hA5}}; resp_delay = 1;
    add_ic(32'h0000_1234);
    serve_one(w);
    wait_idle();
    rd_ovr_en = 0;

    // simultaneous requests, back-to-back
    reset_dut();
    add_ic(32'h0000_2000);
    add_dc(1'b0, 32'h0000_3000, '0);
    for (int k = 0; k < 4; k++) begin
      serve_one(w);
      if (k < 3) begin
        if (w) add_dc(1'b0, 32'h0000_3000 + 32'(k) * 32'h40, '0);
        else   add_ic(32'h0000_2000 + 32'(k) * 32'h40);
      end
    end
`ifdef MEM_ARB_PERF_EN
    checks++;
    if (perf_ic_grants !== 32'(m_nic) || perf_dc_grants !== 32'(m_ndc) || perf_conflicts !== 32'(m_ntie)) begin
      errors++;
      $display("FAIL perf: ic=%0d dc=%0d conf=%0d, expected ic=%0d dc=%0d conf=%0d",
               perf_ic_grants, perf_dc_grants, perf_conflicts, m_nic, m_ndc, m_ntie);
    end
`endif
    serve_one(w);
    wait_idle();

    // dcache write-back
    add_dc(1'b1, 32'h8000_0040, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00);
    serve_one(w);
    wait_idle();

    // memory stall
    stall_left = 5;
    add_ic(32'h0000_5A5C);
    serve_one(w);
    wait_idle();

    // reset during WAIT, late response ignored
    resp_delay = 4; h0 = hs_cnt;
    add_dc(1'b0, 32'h0000_7700, '0);
    serve_one(w);
    n = 0;
    while (hs_cnt == h0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 0;
    model_clear();
    #1 check_outputs_zero("reset_in_wait");
    @(negedge clk);
    rst_n = 1;
    nr = n_resp; n = 0;
    while (rsp_wait >= 0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (n_resp != nr || n >= 50) begin
      errors++;
      $display("FAIL late_resp: %0d resp pulses after reset, expected 0", n_resp - nr);
    end
    resp_delay = 1;
    add_ic(32'h0000_4440);
    serve_one(w);
    wait_idle();

    // randomized traffic
    rand_rdy = 1; spur_en = 1;
    for (int i = 0; i < 80; i++) begin
      resp_delay = $urandom_range(0, 3);
      if (!ic_req_valid && $urandom_range(0, 1) == 1) add_ic($urandom);
      if (!dc_req_valid && $urandom_range(0, 1) == 1)
        add_dc(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom});
      if (!ic_req_valid && !dc_req_valid) add_ic($urandom);
      serve_one(w);
    end
    n = 0;
    while ((ic_req_valid || dc_req_valid) && n < 4) begin serve_one(w); n++; end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single line-wide memory port between the instruction cache refill path and the data cache refill/write-back path. Accepts one request at a time from either cache, arbitrates simultaneous requests round-robin, drives the memory-side request/response handshake, and returns the line to the requester that issued it. Sits between both L1 caches and the external memory interface; it is the sole owner of the memory port.

## Interface
- XLEN, 32: address width (from `constants_pkg`).
- LINE_W, ICLLEN (128): line width in bits; both caches use the same line size.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  icache requests a line refill.
- ic_req_addr  in  XLEN  refill address; byte address within the line is ignored.
- ic_req_ready  out  1  request accepted this cycle.
- ic_resp_valid  out  1  one-cycle pulse; ic_resp_data is valid.
- ic_resp_data  out  LINE_W  refilled line.
- dc_req_valid  in  1  dcache request.
- dc_req_we  in  1  1 = line write-back, 0 = refill.
- dc_req_addr  in  XLEN  line address.
- dc_req_wdata  in  LINE_W  write-back data.
- dc_req_ready  out  1  request accepted this cycle.
- dc_resp_valid  out  1  one-cycle pulse; refill data valid, or write acknowledged.
- dc_resp_data  out  LINE_W  refilled line; zero for writes.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  write request.
- mem_req_addr  out  XLEN  line-aligned address (offset bits forced to 0).
- mem_req_wdata  out  LINE_W  write data.
- mem_resp_valid  in  1  one-cycle response; also the write acknowledge.
- mem_resp_data  in  LINE_W  read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when any req_valid is high, grant one requester and assert its req_ready combinationally in the same cycle. Latch the owner id, we, the aligned address and wdata. Go to ISSUE.
- Arbitration: a single requester wins outright. When both request, the requester not granted last wins. Update last_grant on every grant. After reset, the first tie goes to icache.
- icache requests are always reads (mem_req_we = 0).
- ISSUE: hold mem_req_valid and the request fields stable until mem_req_ready. Go to WAIT on the handshake cycle.
- WAIT: the first mem_resp_valid registers the response data and goes to RESP.
- RESP: assert the owner's resp_valid for exactly one cycle with the registered data; the other requester's resp_valid stays 0. Return to IDLE.
- Requesters must hold req_valid and all req fields stable until req_ready. Dropping req_valid before req_ready withdraws the request.
- mem_resp_valid in IDLE, ISSUE or RESP is ignored.
- Responses carry no ready: requesters must accept the pulse.
- Reset values: all outputs 0; state IDLE; latched fields 0; last_grant = dcache.
- Reset asserted mid-transaction: the transaction is abandoned and no resp_valid is issued. A late mem_resp_valid arriving after reset is ignored (the FSM is in IDLE).

## Timing
- Request accepted in cycle T.
- mem_req_valid high from T+1.
- With mem_req_ready = 1 at T+1, the state is WAIT at T+2.
- mem_resp_valid arrives no earlier than T+2 (memory contract). A response at cycle R gives resp_valid at R+1.
- The next request can be accepted at R+2.
- Minimum request-to-response latency: 3 cycles.
- Only one memory transaction is outstanding at a time.

## Configuration
- MEM_ARB_PERF_EN defined: adds three output ports, each 32 bits, wrapping at overflow and cleared by reset:
  - perf_ic_grants: +1 per icache grant.
  - perf_dc_grants: +1 per dcache grant.
  - perf_conflicts: +1 per IDLE cycle in which both requesters are valid.
- MEM_ARB_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- `constants_pkg` holds:
  - `mem_arb_state_t` (IDLE, ISSUE, WAIT, RESP);
  - `mem_req_id_t` (REQ_IC, REQ_DC);
  - the existing XLEN and ICLLEN constants.
- Sub-module `rr_arb2`: purely combinational 2-way round-robin grant from (req[1:0], last_grant). It is reused later for the dcache port.

## Test plan
- Single icache refill: ic_req_addr = 0x0000_1234, memory returns 0xA5…A5 two cycles after the handshake. Expected: mem_req_addr = 0x0000_1230, mem_req_we = 0, ic_resp_valid pulses one cycle with 0xA5…A5, dc_resp_valid stays 0.
- Simultaneous requests, repeated 4 times back-to-back. Expected grant order after reset: IC, DC, IC, DC. Each response goes only to its owner.
- dcache write-back: we = 1, addr 0x8000_0040, wdata 0x1122…. Expected: mem_req_we = 1 with wdata forwarded; dc_resp_valid pulses on the ack with dc_resp_data = 0.
- mem_req_ready held low 5 cycles. Expected: mem_req_valid and all fields stable for 5 cycles; no second req_ready is asserted meanwhile.
- rst_n pulsed low during WAIT. Expected: all outputs 0 immediately; a following mem_resp_valid produces no resp_valid; a new request is then served normally.
- MEM_ARB_PERF_EN defined, after the arbitration test. Expected: perf_ic_grants = 2, perf_dc_grants = 2, perf_conflicts ≥ 4.
